uc_arbiter: RTL and testbench
=============================

Name: uc_arbiter

Overview:
- Unit clause arbiter between the processing engines and the unit clause queue.
- Collects unit-clause literals from NUM_ENG engines with round-robin arbitration, at most one push per cycle.
- Pops literals from the queue and broadcasts each one to all engines, holding it until every engine has acknowledged.
- Reports global idle so the top level can detect a propagation fixpoint.

Parameters:
- NUM_ENG, 4, number of processing engines (requesters and broadcast consumers); power of two, at least 2.
- DATA_LEN, 512, literal range; LIT_W = $clog2(DATA_LEN) is the signed literal width, matching the queue data width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  abort any in-flight broadcast; FSM returns to IDLE.
- eng_uc_valid  in  NUM_ENG  engine i offers a unit literal.
- eng_uc_lit  in  NUM_ENG x LIT_W (signed)  literal from engine i.
- eng_uc_ready  out  NUM_ENG  one-hot grant; literal i is accepted this cycle.
- q_push  out  1  queue push.
- q_data  out  LIT_W (signed)  queue push data.
- q_full  in  1  queue full.
- q_pop  out  1  queue pop.
- q_empty  in  1  queue empty.
- q_qout  in  LIT_W (signed)  queue output; valid combinationally in the cycle q_pop is asserted.
- bcast_valid  out  1  broadcast literal valid.
- bcast_lit  out  LIT_W (signed)  broadcast literal (registered).
- bcast_ack  in  NUM_ENG  per-engine acknowledge of the current broadcast.
- uc_count  out  16  number of completed broadcasts; wraps modulo 2^16.
- idle  out  1  nothing pending anywhere.

Behaviour:
Reset (rst_n=0 at a clock edge):
- state=IDLE, rr_ptr=0, ack_mask=0, bcast_lit=0, uc_count=0.
- While rst_n=0, eng_uc_ready, q_push, q_pop and bcast_valid are forced to 0.

Push arbitration (combinational grant, registered pointer):
- Grant g is the first i with eng_uc_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_ENG.
- A grant is issued only if some valid is set and q_full=0. On grant: eng_uc_ready[g]=1, q_push=1, q_data=eng_uc_lit[g], and rr_ptr <= (g+1) mod NUM_ENG.
- q_full=1: no grant, all ready bits 0, rr_ptr held.
- Never assert q_push when q_full=1, including a cycle with simultaneous q_pop.
- Push arbitration is independent of the broadcast FSM and of flush.

Broadcast FSM, states IDLE and BCAST:
- IDLE: if q_empty=0, assert q_pop for exactly one cycle, latch bcast_lit <= q_qout, go to BCAST. If q_empty=1, q_pop=0 and stay in IDLE.
- Never assert q_pop when q_empty=1, even if q_push is asserted in the same cycle. The queue's push+pop path does not check empty.
- BCAST: bcast_valid=1; ack_mask <= ack_mask | bcast_ack.
- BCAST completes when (ack_mask | bcast_ack) is all ones; acks may arrive in the same cycle or spread over many. On completion: ack_mask <= 0, uc_count <= uc_count+1, go to IDLE.
- bcast_valid drops in the cycle after completion.
- Minimum throughput is one literal per 2 cycles (pop cycle, then at least one BCAST cycle).
- bcast_ack bits seen in IDLE are ignored.
- bcast_lit is stable for the whole BCAST residency.

Flush:
- In BCAST, flush forces state <= IDLE and ack_mask <= 0 with no uc_count increment. The popped literal is discarded.
- In IDLE, flush suppresses q_pop that cycle.
- flush takes priority over completion in the same cycle.

idle:
- idle = (state==IDLE) && q_empty && no eng_uc_valid bit set.
- Combinational; 0 during reset.

Test Plan:
- Reset then single push: rst_n=0 for 2 cycles, then eng_uc_valid=4'b0100, lit=+7, queue empty -> eng_uc_ready=4'b0100, q_push=1, q_data=7, rr_ptr becomes 3.
- Round-robin fairness: all 4 engines valid continuously with literals 1,2,3,4, queue never full -> grants in the order 0,1,2,3,0, each for one cycle.
- Queue full back-pressure: q_full=1 with eng 1 valid -> no ready and no q_push. Deassert q_full -> eng 1 granted the next cycle with rr_ptr unchanged.
- Broadcast with staggered acks: queue holds -5 -> q_pop one cycle, bcast_lit=-5, bcast_valid=1. Acks 4'b0011 then 4'b1100 on the next cycle -> completion, bcast_valid=0 the following cycle, uc_count=1.
- Empty-queue and flush: q_empty=1 with push active -> q_pop never asserted. In BCAST with acks 4'b0001, assert flush -> state IDLE, uc_count unchanged, ack_mask cleared, and the next literal is popped the cycle after.
- Idle detection: queue empty, no valids, FSM in IDLE -> idle=1. Raise eng_uc_valid[2] -> idle=0 in the same cycle.

Source files
------------

// File: rtl/uc_arbiter.sv
// Unit clause arbiter: round-robin collection of engine literals into the unit clause queue,
// and pop-and-broadcast of queued literals to all engines until every engine has acknowledged.
module uc_arbiter #(
    parameter int unsigned NUM_ENG  = 4,
    parameter int unsigned DATA_LEN = 512,
    localparam int unsigned LIT_W   = $clog2(DATA_LEN)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [NUM_ENG-1:0]              eng_uc_valid,
    input  logic [NUM_ENG-1:0][LIT_W-1:0]   eng_uc_lit,
    output logic [NUM_ENG-1:0]              eng_uc_ready,
    output logic                            q_push,
    output logic signed [LIT_W-1:0]         q_data,
    input  logic                            q_full,
    output logic                            q_pop,
    input  logic                            q_empty,
    input  logic signed [LIT_W-1:0]         q_qout,
    output logic                            bcast_valid,
    output logic signed [LIT_W-1:0]         bcast_lit,
    input  logic [NUM_ENG-1:0]              bcast_ack,
    output logic [15:0]                     uc_count,
    output logic                            idle
);

    localparam int unsigned PTR_W = $clog2(NUM_ENG);

    typedef enum logic [0:0] {
        StIdle,
        StBcast
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_ENG-1:0]      ack_mask_q, ack_mask_d;
    logic signed [LIT_W-1:0] bcast_lit_q, bcast_lit_d;
    logic [15:0]             uc_count_q, uc_count_d;

    logic [PTR_W-1:0]        gnt_idx;
    logic [PTR_W-1:0]        cand;
    logic                    gnt_found;
    logic                    push_en;
    logic [NUM_ENG-1:0]      ack_seen;

    // Rotating priority search starting at rr_ptr; NUM_ENG is a power of two so the
    // pointer addition wraps naturally.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            cand = rr_ptr_q + PTR_W'(k);
            if (!gnt_found && eng_uc_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        push_en      = rst_n && gnt_found && !q_full;
        eng_uc_ready = '0;
        if (push_en) begin
            eng_uc_ready[gnt_idx] = 1'b1;
        end
        q_push   = push_en;
        q_data   = $signed(eng_uc_lit[gnt_idx]);
        rr_ptr_d = push_en ? gnt_idx + PTR_W'(1) : rr_ptr_q;
    end

    // Broadcast FSM: pop one literal, hold it until all engines have acknowledged.
    always_comb begin
        state_d     = state_q;
        ack_mask_d  = ack_mask_q;
        bcast_lit_d = bcast_lit_q;
        uc_count_d  = uc_count_q;
        q_pop       = 1'b0;
        bcast_valid = 1'b0;
        ack_seen    = ack_mask_q | bcast_ack;

        case (state_q)
            StIdle: begin
                // The queue does not guard pop-on-empty, so empty is checked here.
                if (rst_n && !q_empty && !flush) begin
                    q_pop       = 1'b1;
                    bcast_lit_d = q_qout;
                    state_d     = StBcast;
                end
            end
            StBcast: begin
                bcast_valid = rst_n;
                if (flush) begin
                    state_d    = StIdle;
                    ack_mask_d = '0;
                end else if (&ack_seen) begin
                    state_d    = StIdle;
                    ack_mask_d = '0;
                    uc_count_d = uc_count_q + 16'd1;
                end else begin
                    ack_mask_d = ack_seen;
                end
            end
            default: begin
                state_d    = StIdle;
                ack_mask_d = '0;
            end
        endcase
    end

    always_comb begin
        idle = rst_n && (state_q == StIdle) && q_empty && !(|eng_uc_valid);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            ack_mask_q  <= '0;
            bcast_lit_q <= '0;
            uc_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            ack_mask_q  <= ack_mask_d;
            bcast_lit_q <= bcast_lit_d;
            uc_count_q  <= uc_count_d;
        end
    end

    assign bcast_lit = bcast_lit_q;
    assign uc_count  = uc_count_q;

endmodule

// File: tb/tb_uc_arbiter.sv
// Directed bench for uc_arbiter: a vector table with hand-computed outputs per cycle,
// followed by a staggered-ack broadcast sequence with a bounded wait.
module tb_uc_arbiter;

    localparam int NE = 4;
    localparam int LW = 9;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        flush;
    logic [NE-1:0]               eng_uc_valid;
    logic [NE-1:0][LW-1:0]       eng_uc_lit;
    logic [NE-1:0]               eng_uc_ready;
    logic                        q_push;
    logic signed [LW-1:0]        q_data;
    logic                        q_full;
    logic                        q_pop;
    logic                        q_empty;
    logic signed [LW-1:0]        q_qout;
    logic                        bcast_valid;
    logic signed [LW-1:0]        bcast_lit;
    logic [NE-1:0]               bcast_ack;
    logic [15:0]                 uc_count;
    logic                        idle;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uc_arbiter #(.NUM_ENG(NE), .DATA_LEN(512)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .eng_uc_valid (eng_uc_valid),
        .eng_uc_lit   (eng_uc_lit),
        .eng_uc_ready (eng_uc_ready),
        .q_push       (q_push),
        .q_data       (q_data),
        .q_full       (q_full),
        .q_pop        (q_pop),
        .q_empty      (q_empty),
        .q_qout       (q_qout),
        .bcast_valid  (bcast_valid),
        .bcast_lit    (bcast_lit),
        .bcast_ack    (bcast_ack),
        .uc_count     (uc_count),
        .idle         (idle)
    );

    typedef struct {
        logic                 rst_n;
        logic                 flush;
        logic [NE-1:0]        valid;
        logic signed [LW-1:0] lit2;
        logic                 full;
        logic                 empty;
        logic signed [LW-1:0] qout;
        logic [NE-1:0]        ack;
        logic [NE-1:0]        rdy;
        logic                 push;
        logic signed [LW-1:0] data;
        logic                 pop;
        logic                 bv;
        logic signed [LW-1:0] blit;
        logic [15:0]          cnt;
        logic                 idl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int r, input int fl, input logic [3:0] val, input int l2,
                                input int full, input int emp, input int qo,
                                input logic [3:0] ack, input logic [3:0] rdy, input int push,
                                input int data, input int pop, input int bv, input int blit,
                                input int cnt, input int idl);
        vec_t v;
        v.rst_n = 1'(r);   v.flush = 1'(fl);  v.valid = val;     v.lit2 = LW'(l2);
        v.full  = 1'(full); v.empty = 1'(emp); v.qout = LW'(qo);  v.ack  = ack;
        v.rdy   = rdy;     v.push  = 1'(push); v.data = LW'(data); v.pop = 1'(pop);
        v.bv    = 1'(bv);  v.blit  = LW'(blit); v.cnt = 16'(cnt); v.idl = 1'(idl);
        vecs.push_back(v);
    endfunction

    task automatic check1(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; eng_uc_valid = '0; q_full = 1'b0; q_empty = 1'b1;
        q_qout = '0; bcast_ack = '0;
        eng_uc_lit = {LW'(4), LW'(3), LW'(2), LW'(1)};

        //  rst fl valid   l2 full emp qout ack   | rdy    push data pop bv blit cnt idle
        add(0, 0, 4'b1111, 3, 0, 0, 0,   4'b0000,  4'b0000, 0, 0, 0, 0, 0,   0, 0);
        add(1, 0, 4'b0100, 7, 0, 1, 0,   4'b0000,  4'b0100, 1, 7, 0, 0, 0,   0, 0);
        add(1, 0, 4'b1111, 3, 0, 1, 0,   4'b0000,  4'b1000, 1, 4, 0, 0, 0,   0, 0);
        add(1, 0, 4'b1111, 3, 0, 1, 0,   4'b0000,  4'b0001, 1, 1, 0, 0, 0,   0, 0);
        add(1, 0, 4'b1111, 3, 0, 1, 0,   4'b0000,  4'b0010, 1, 2, 0, 0, 0,   0, 0);
        add(1, 0, 4'b1111, 3, 0, 1, 0,   4'b0000,  4'b0100, 1, 3, 0, 0, 0,   0, 0);
        add(1, 0, 4'b1111, 3, 0, 1, 0,   4'b0000,  4'b1000, 1, 4, 0, 0, 0,   0, 0);
        add(1, 0, 4'b1111, 3, 0, 1, 0,   4'b0000,  4'b0001, 1, 1, 0, 0, 0,   0, 0);
        add(1, 0, 4'b0010, 3, 1, 1, 0,   4'b0000,  4'b0000, 0, 0, 0, 0, 0,   0, 0);
        add(1, 0, 4'b1111, 3, 1, 1, 0,   4'b0000,  4'b0000, 0, 0, 0, 0, 0,   0, 0);
        add(1, 0, 4'b1111, 3, 0, 1, 0,   4'b0000,  4'b0010, 1, 2, 0, 0, 0,   0, 0);
        add(1, 0, 4'b0010, 3, 0, 1, 0,   4'b0000,  4'b0010, 1, 2, 0, 0, 0,   0, 0);
        add(1, 0, 4'b0000, 3, 0, 0, -5,  4'b1111,  4'b0000, 0, 0, 1, 0, 0,   0, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b0011,  4'b0000, 0, 0, 0, 1, -5,  0, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b1100,  4'b0000, 0, 0, 0, 1, -5,  0, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b0000,  4'b0000, 0, 0, 0, 0, -5,  1, 1);
        add(1, 0, 4'b0100, 9, 0, 1, 0,   4'b0000,  4'b0100, 1, 9, 0, 0, -5,  1, 0);
        add(1, 0, 4'b0000, 3, 0, 0, 12,  4'b0000,  4'b0000, 0, 0, 1, 0, -5,  1, 0);
        add(1, 0, 4'b0000, 3, 0, 0, 20,  4'b0001,  4'b0000, 0, 0, 0, 1, 12,  1, 0);
        add(1, 1, 4'b0000, 3, 0, 0, 20,  4'b1110,  4'b0000, 0, 0, 0, 1, 12,  1, 0);
        add(1, 0, 4'b0000, 3, 0, 0, 20,  4'b0000,  4'b0000, 0, 0, 1, 0, 12,  1, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b1110,  4'b0000, 0, 0, 0, 1, 20,  1, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b0000,  4'b0000, 0, 0, 0, 1, 20,  1, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b0001,  4'b0000, 0, 0, 0, 1, 20,  1, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b0000,  4'b0000, 0, 0, 0, 0, 20,  2, 1);
        add(1, 1, 4'b0000, 3, 0, 0, 33,  4'b0000,  4'b0000, 0, 0, 0, 0, 20,  2, 0);
        add(1, 0, 4'b0001, 3, 1, 0, 33,  4'b0000,  4'b0000, 0, 0, 1, 0, 20,  2, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b1111,  4'b0000, 0, 0, 0, 1, 33,  2, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b0000,  4'b0000, 0, 0, 0, 0, 33,  3, 1);
        add(0, 0, 4'b1111, 3, 0, 0, 7,   4'b1111,  4'b0000, 0, 0, 0, 0, 33,  3, 0);
        add(1, 0, 4'b0000, 3, 0, 1, 0,   4'b0000,  4'b0000, 0, 0, 0, 0, 0,   0, 1);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            vec_t v;
            logic signed [LW-1:0] act_data;
            logic signed [LW-1:0] exp_data;
            v = vecs[i];
            rst_n = v.rst_n; flush = v.flush; eng_uc_valid = v.valid; q_full = v.full;
            q_empty = v.empty; q_qout = v.qout; bcast_ack = v.ack;
            eng_uc_lit = {LW'(4), v.lit2, LW'(2), LW'(1)};
            #4;
            act_data = q_push ? q_data : '0;
            exp_data = v.push ? v.data : '0;
            n_cmp++;
            if (eng_uc_ready !== v.rdy || q_push !== v.push || act_data !== exp_data ||
                q_pop !== v.pop || bcast_valid !== v.bv || bcast_lit !== v.blit ||
                uc_count !== v.cnt || idle !== v.idl) begin
                n_bad++;
                $display("FAIL vec%0d: got rdy=%b push=%b data=%0d pop=%b bv=%b lit=%0d cnt=%0d idle=%b; want rdy=%b push=%b data=%0d pop=%b bv=%b lit=%0d cnt=%0d idle=%b",
                         i, eng_uc_ready, q_push, act_data, q_pop, bcast_valid, bcast_lit,
                         uc_count, idle, v.rdy, v.push, exp_data, v.pop, v.bv, v.blit,
                         v.cnt, v.idl);
            end
            @(posedge clk);
            #1;
        end

        // One ack bit per cycle; the literal must stay put until the last one lands.
        rst_n = 1'b1; flush = 1'b0; eng_uc_valid = '0; q_full = 1'b0; bcast_ack = '0;
        q_empty = 1'b0; q_qout = -9'sd100;
        #4;
        check1("spread_pop", int'(q_pop), 1);
        @(posedge clk);
        #1;
        q_empty = 1'b1; q_qout = '0;
        for (int k = 0; k < NE; k++) begin
            bcast_ack = '0;
            bcast_ack[k] = 1'b1;
            #4;
            check1($sformatf("spread_bv%0d", k), int'(bcast_valid), 1);
            check1($sformatf("spread_lit%0d", k), int'(bcast_lit), -100);
            @(posedge clk);
            #1;
        end
        bcast_ack = '0;
        begin
            bit dropped;
            dropped = 1'b0;
            for (int c = 0; c < 4 && !dropped; c++) begin
                #4;
                if (!bcast_valid) begin
                    dropped = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
            check1("spread_drop_timeout", int'(dropped), 1);
        end
        check1("spread_cnt", int'(uc_count), 1);
        check1("spread_idle", int'(idle), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
